// File: rtl/cyc_pkg.sv
// cyc_pkg: shared types and constants for the cycle computer datapath
package cyc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} sched_state_t;
  localparam int DIV_W = 32;
  localparam int CADENCE_DIVD = 768000;
endpackage

// File: rtl/div_scheduler_if.sv
// div_scheduler_if: requester-side and divider-side signals of the divider scheduler
interface div_scheduler_if #(
  parameter int N = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ*N-1:0] op_divd;
  logic [NREQ*N-1:0] op_dvsr;
  logic [N-1:0] res_q;
  logic [N-1:0] res_r;
  logic res_err;
  logic busy;
  logic [N-1:0] div_divd;
  logic [N-1:0] div_dvsr;
  logic div_start;
  logic [N-1:0] div_q;
  logic [N-1:0] div_r;
  logic div_ready;
  modport master (
    input req, op_divd, op_dvsr, div_q, div_r, div_ready,
    output done, res_q, res_r, res_err, busy, div_divd, div_dvsr, div_start
  );
  modport slave (
    output req, op_divd, op_dvsr, div_q, div_r, div_ready,
    input done, res_q, res_r, res_err, busy, div_divd, div_dvsr, div_start
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic [NREQ-1:0] grant,
  output logic [W-1:0]    idx
);
  logic [NREQ-1:0] rot;
  logic [W-1:0] off;
  logic [W:0] sum;
  // rotate so bit 0 is the requester at ptr, then the lowest set bit wins
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= (W+1)'(NREQ) ? W'(sum - (W+1)'(NREQ)) : sum[W-1:0];
    grant = |req ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin time-sharing of one sequential divider among NREQ requesters
module div_scheduler
  import cyc_pkg::*;
#(
  parameter int N = DIV_W,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 1024
) (
  input logic clock,
  input logic Rst,
  div_scheduler_if.master bus
);
  localparam int W = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  sched_state_t state, state_d;
  logic [W-1:0] ptr, g, gidx;
  logic [NREQ-1:0] grant, gsel;
  logic [CW-1:0] cnt;
  logic [N-1:0] sel_divd, sel_dvsr, divd, dvsr, res_q, res_r;
  logic res_err, timed_out, zero_div;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(bus.req),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx)
  );
  always_comb begin
    sel_divd = '0;
    sel_dvsr = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_divd = gidx == W'(i) ? bus.op_divd[i*N +: N] : sel_divd;
      sel_dvsr = gidx == W'(i) ? bus.op_dvsr[i*N +: N] : sel_dvsr;
    end
  end
  assign zero_div = sel_dvsr == '0;
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    bus.div_start = 1'b0;
    bus.busy = state != IDLE;
    bus.done = '0;
    case (state)
      IDLE: state_d = |bus.req ? (zero_div ? RESP : LOAD) : IDLE;
      LOAD: begin
        state_d = WAIT;
        bus.div_start = 1'b1;
      end
      // ready is only trusted from WAIT on; a stale ready during LOAD is ignored
      WAIT: state_d = (bus.div_ready || timed_out) ? RESP : WAIT;
      default: begin
        state_d = IDLE;
        bus.done = gsel;
      end
    endcase
  end
  always_ff @(posedge clock or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      gsel <= '0;
      cnt <= '0;
      divd <= '0;
      dvsr <= '0;
      res_q <= '0;
      res_r <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (|bus.req) begin
          g <= gidx;
          gsel <= grant;
          divd <= sel_divd;
          dvsr <= sel_dvsr;
          if (zero_div) begin
            res_q <= '0;
            res_r <= sel_divd;
            res_err <= 1'b1;
          end
        end
        LOAD: cnt <= '0;
        WAIT: if (bus.div_ready) begin
          res_q <= bus.div_q;
          res_r <= bus.div_r;
          res_err <= 1'b0;
        end else if (timed_out) begin
          res_q <= '0;
          res_r <= '0;
          res_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: ptr <= g == W'(NREQ - 1) ? '0 : g + 1'b1;
      endcase
    end
  end
  assign bus.div_divd = divd;
  assign bus.div_dvsr = dvsr;
  assign bus.res_q = res_q;
  assign bus.res_r = res_r;
  assign bus.res_err = res_err;
endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: scoreboard bench for div_scheduler with a behavioural divider of configurable latency
module tb_div_scheduler;
  import cyc_pkg::*;
  typedef struct {
    int idx;
    logic [31:0] q;
    logic [31:0] r;
    logic err;
  } exp_t;
  logic clock, Rst;
  div_scheduler_if #(.N(32), .NREQ(4)) bus ();
  div_scheduler #(.N(32), .NREQ(4), .TIMEOUT(16)) dut (
    .clock(clock),
    .Rst(Rst),
    .bus(bus)
  );
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int starts = 0;
  int lat = 1;
  logic hang = 1'b0;
  int dcnt;
  logic [31:0] pq, pr;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // behavioural divider: ready rises lat cycles after start and lingers until the next start
  always @(posedge clock or posedge Rst) begin
    if (Rst) begin
      bus.div_ready <= 1'b0;
      bus.div_q <= '0;
      bus.div_r <= '0;
      dcnt <= 0;
    end else if (bus.div_start) begin
      pq <= bus.div_divd / bus.div_dvsr;
      pr <= bus.div_divd % bus.div_dvsr;
      dcnt <= lat - 1;
      bus.div_ready <= (lat == 1) && !hang;
      if (lat == 1) begin
        bus.div_q <= bus.div_divd / bus.div_dvsr;
        bus.div_r <= bus.div_divd % bus.div_dvsr;
      end
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        bus.div_ready <= 1'b1;
        bus.div_q <= pq;
        bus.div_r <= pr;
      end
    end
  end
  always @(negedge clock) if (bus.div_start) starts++;
  always @(negedge clock) begin
    if (bus.done != '0) begin
      chk("done_onehot", 32'($onehot(bus.done)), 1);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=%b, expected no done", bus.done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_requester", 32'(bus.done), 32'(4'b0001 << e.idx));
        chk("res_q", bus.res_q, e.q);
        chk("res_r", bus.res_r, e.r);
        chk("res_err", 32'(bus.res_err), 32'(e.err));
      end
    end
  end
  task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         output int cyc);
    exp_t e;
    @(negedge clock);
    bus.op_divd[idx*32 +: 32] = a;
    bus.op_dvsr[idx*32 +: 32] = b;
    e.idx = idx;
    e.q = eq;
    e.r = er;
    e.err = ee;
    sb.push_back(e);
    bus.req[idx] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.done[idx] && cyc < 200);
    bus.req[idx] = 1'b0;
    if (!bus.done[idx]) begin
      compared++;
      mismatched++;
      $display("FAIL no_done_req%0d: got no done in %0d cycles, expected a done pulse", idx, cyc);
      sb.delete();
    end
  endtask
  initial begin
    int cyc, s0, n;
    logic second0;
    Rst = 1'b1;
    bus.req = '0;
    bus.op_divd = '0;
    bus.op_dvsr = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_res_q", bus.res_q, 0);
    chk("rst_res_r", bus.res_r, 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    chk("rst_div_start", 32'(bus.div_start), 0);
    chk("rst_div_divd", bus.div_divd, 0);
    chk("rst_div_dvsr", bus.div_dvsr, 0);
    Rst = 1'b0;
    // contention: all four held, requester 0 re-requests with new operands after its first done
    lat = 2;
    @(negedge clock);
    bus.op_divd = {32'd12345, 32'd65535, 32'd1000, 32'd100};
    bus.op_dvsr = {32'd100, 32'd256, 32'd33, 32'd7};
    sb.push_back('{0, 32'd14, 32'd2, 1'b0});
    sb.push_back('{1, 32'd30, 32'd10, 1'b0});
    sb.push_back('{2, 32'd255, 32'd255, 1'b0});
    sb.push_back('{3, 32'd123, 32'd45, 1'b0});
    sb.push_back('{0, 32'd7, 32'd1, 1'b0});
    bus.req = 4'b1111;
    second0 = 1'b0;
    n = 0;
    while (bus.req != '0 && n < 300) begin
      @(negedge clock);
      n++;
      for (int i = 0; i < 4; i++) if (bus.done[i]) begin
        if (i == 0 && !second0) begin
          second0 = 1'b1;
          bus.op_divd[31:0] = 32'd50;
        end else bus.req[i] = 1'b0;
      end
    end
    chk("contention_all_served", 32'(bus.req), 0);
    // single request with an immediately ready divider
    lat = 1;
    s0 = starts;
    run_one(0, CADENCE_DIVD, 32'd12800, 32'd60, 32'd0, 1'b0, cyc);
    chk("single_latency", 32'(cyc), 3);
    chk("single_one_start", 32'(starts - s0), 1);
    // divide by zero never starts the divider
    s0 = starts;
    run_one(2, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, cyc);
    chk("div0_no_start", 32'(starts - s0), 0);
    // ready still high from the 768000/12800 op during LOAD must not be captured
    lat = 3;
    run_one(3, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, cyc);
    // divider never answers
    hang = 1'b1;
    run_one(1, 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, cyc);
    chk("timeout_min_wait", 32'(cyc >= 16), 1);
    hang = 1'b0;
    lat = 1;
    run_one(3, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, cyc);
    // reset in the middle of WAIT
    lat = 6;
    @(negedge clock);
    bus.op_divd[31:0] = 32'd500;
    bus.op_dvsr[31:0] = 32'd4;
    bus.req[0] = 1'b1;
    repeat (3) @(negedge clock);
    chk("midwait_busy", 32'(bus.busy), 1);
    Rst = 1'b1;
    #1;
    bus.req[0] = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_res_q", bus.res_q, 0);
    chk("midrst_res_r", bus.res_r, 0);
    chk("midrst_res_err", 32'(bus.res_err), 0);
    chk("midrst_div_start", 32'(bus.div_start), 0);
    chk("midrst_div_divd", bus.div_divd, 0);
    chk("midrst_div_dvsr", bus.div_dvsr, 0);
    @(negedge clock);
    Rst = 1'b0;
    lat = 2;
    run_one(2, CADENCE_DIVD, 32'd12800, 32'd60, 32'd0, 1'b0, cyc);
    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
